// File: rtl/pixel_write_arbiter.sv
// Two-requester round-robin pixel write arbiter with a full-screen clear sequencer.
// The framebuffer write port is registered: every accepted pixel or clear pixel appears one cycle later.
module pixel_write_arbiter #(
    parameter int COLOR_CHANNEL_DEPTH = 2,
    parameter int X_PIXELS            = 160,
    parameter int Y_PIXELS            = 120,
    localparam int CW                 = 3 * COLOR_CHANNEL_DEPTH
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [7:0]    x0,
    input  logic [6:0]    y0,
    input  logic [CW-1:0] color0,
    input  logic          valid0,
    output logic          ready0,
    input  logic [7:0]    x1,
    input  logic [6:0]    y1,
    input  logic [CW-1:0] color1,
    input  logic          valid1,
    output logic          ready1,
    input  logic          clear_req,
    input  logic [CW-1:0] clear_color,
    output logic          clear_busy,
    output logic [7:0]    x,
    output logic [6:0]    y,
    output logic [CW-1:0] color,
    output logic          writeEn
);
    typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

    localparam logic [7:0] XMAX = 8'(X_PIXELS - 1);
    localparam logic [6:0] YMAX = 7'(Y_PIXELS - 1);

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [7:0]    cx_q, cx_d;
    logic [6:0]    cy_q, cy_d;
    logic [CW-1:0] ccolor_q, ccolor_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [CW-1:0] color_q, color_d;
    logic          we_q, we_d;

    logic          sel, any_valid, xfer, clear_last;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ARB;
            last_grant_q <= 1'b1;
            cx_q         <= '0;
            cy_q         <= '0;
            ccolor_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            color_q      <= '0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            ccolor_q     <= ccolor_d;
            x_q          <= x_d;
            y_q          <= y_d;
            color_q      <= color_d;
            we_q         <= we_d;
        end
    end

    assign clear_last = (cx_q == XMAX) && (cy_q == YMAX);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (clear_req)  state_d = CLEAR;
            CLEAR:   if (clear_last) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Output logic: round-robin handshake and status
    always_comb begin
        sel       = 1'b0;
        any_valid = 1'b0;
        if (valid0 && valid1) begin
            sel       = ~last_grant_q;
            any_valid = 1'b1;
        end else if (valid0) begin
            any_valid = 1'b1;
        end else if (valid1) begin
            sel       = 1'b1;
            any_valid = 1'b1;
        end
        ready0     = (state_q == ARB) && !clear_req && any_valid && !sel;
        ready1     = (state_q == ARB) && !clear_req && any_valid && sel;
        xfer       = ready0 || ready1;
        clear_busy = (state_q == CLEAR);
    end

    // Datapath: write port defaults to all-zero when nothing is written
    always_comb begin
        last_grant_d = last_grant_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        ccolor_d     = ccolor_q;
        x_d          = '0;
        y_d          = '0;
        color_d      = '0;
        we_d         = 1'b0;
        if (state_q == ARB) begin
            if (clear_req) begin
                cx_d     = '0;
                cy_d     = '0;
                ccolor_d = clear_color;
            end else if (xfer) begin
                last_grant_d = sel;
                x_d          = sel ? x1 : x0;
                y_d          = sel ? y1 : y0;
                color_d      = sel ? color1 : color0;
                we_d         = 1'b1;
            end
        end else begin
            x_d     = cx_q;
            y_d     = cy_q;
            color_d = ccolor_q;
            we_d    = 1'b1;
            if (cx_q == XMAX) begin
                cx_d = '0;
                cy_d = (cy_q == YMAX) ? '0 : cy_q + 7'd1;
            end else begin
                cx_d = cx_q + 8'd1;
            end
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign color   = color_q;
    assign writeEn = we_q;
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Randomized scoreboard bench for pixel_write_arbiter: a reference model predicts grants and
// clear pixels (indexed linearly over the screen), a monitor pops and compares every write.
module tb_pixel_write_arbiter;
    localparam int XP = 160;
    localparam int YP = 120;

    logic       clock, resetn;
    logic [7:0] x0, x1, x;
    logic [6:0] y0, y1, y;
    logic [5:0] color0, color1, clear_color, color;
    logic       valid0, valid1, ready0, ready1, clear_req, clear_busy, writeEn;

    pixel_write_arbiter dut (
        .clock(clock), .resetn(resetn),
        .x0(x0), .y0(y0), .color0(color0), .valid0(valid0), .ready0(ready0),
        .x1(x1), .y1(y1), .color1(color1), .valid1(valid1), .ready1(ready1),
        .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
        .x(x), .y(y), .color(color), .writeEn(writeEn)
    );

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [5:0] pc;
    } pix_t;

    pix_t exp_q[$];
    int   nchecks = 0;
    int   nerr    = 0;

    // reference model state
    bit   mclear = 0;
    int   k      = 0;
    int   last   = 1;
    logic [5:0] mcol = '0;

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor
    always @(negedge clock) begin
        pix_t e;
        chk("writeEn", int'(writeEn), int'(exp_q.size() > 0));
        if (writeEn && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_x", int'(x), int'(e.px));
            chk("wr_y", int'(y), int'(e.py));
            chk("wr_color", int'(color), int'(e.pc));
        end else if (!writeEn) begin
            chk("idle_xyc", int'({x, y, color}), 0);
        end
    end

    // One cycle: check handshake against the model, advance the model, wait for the next negedge.
    task automatic step(output bit t0, output bit t1);
        bit e0, e1;
        pix_t p;
        #1;
        t0 = 0; t1 = 0; e0 = 0; e1 = 0;
        if (!mclear && !clear_req) begin
            if (valid0 && valid1) begin
                if (last == 1) e0 = 1; else e1 = 1;
            end else begin
                e0 = valid0;
                e1 = valid1;
            end
        end
        chk("ready0", int'(ready0), int'(e0));
        chk("ready1", int'(ready1), int'(e1));
        chk("clear_busy", int'(clear_busy), int'(mclear));
        if (mclear) begin
            p.px = 8'(k % XP);
            p.py = 7'(k / XP);
            p.pc = mcol;
            exp_q.push_back(p);
            k++;
            if (k == XP * YP) mclear = 0;
        end else if (clear_req) begin
            mclear = 1;
            k      = 0;
            mcol   = clear_color;
        end else if (e0) begin
            p.px = x0; p.py = y0; p.pc = color0;
            exp_q.push_back(p);
            last = 0; t0 = 1;
        end else if (e1) begin
            p.px = x1; p.py = y1; p.pc = color1;
            exp_q.push_back(p);
            last = 1; t1 = 1;
        end
        @(negedge clock);
        #1;
    endtask

    // A requester keeps its request until it is transferred, then may raise a fresh one.
    task automatic renew(input bit t0, input bit t1);
        if (!valid0 || t0) begin
            valid0 = 1'($urandom_range(0, 1));
            x0 = 8'($urandom); y0 = 7'($urandom); color0 = 6'($urandom);
        end
        if (!valid1 || t1) begin
            valid1 = 1'($urandom_range(0, 1));
            x1 = 8'($urandom); y1 = 7'($urandom); color1 = 6'($urandom);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        mclear = 0; k = 0; last = 1; mcol = '0;
    endtask

    task automatic do_reset();
        resetn = 0;
        #1;
        chk("rst_out", int'({writeEn, x, y, color}), 0);
        chk("rst_busy", int'(clear_busy), 0);
        reset_model();
        @(negedge clock);
        #1;
        resetn = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit t0, t1;
        int cap;
        resetn = 0; clear_req = 0; clear_color = '0;
        valid0 = 1; x0 = '0; y0 = '0; color0 = '0;
        valid1 = 0; x1 = '0; y1 = '0; color1 = '0;
        #3;
        chk("rst_ready0", int'(ready0), 1);
        chk("rst_ready1", int'(ready1), 0);
        chk("rst_out", int'({writeEn, x, y, color}), 0);
        chk("rst_busy", int'(clear_busy), 0);
        valid0 = 0;
        @(negedge clock);
        #1;
        resetn = 1;
        repeat (4) step(t0, t1);

        // single requester 0 pixel
        valid0 = 1; x0 = 8'd10; y0 = 7'd20; color0 = 6'h15;
        step(t0, t1);
        valid0 = 0;
        chk("single_xyc", int'({writeEn, x, y, color}), int'({1'b1, 8'd10, 7'd20, 6'h15}));
        step(t0, t1);

        // contention right after reset alternates 0,1,0,1
        do_reset();
        valid0 = 1; valid1 = 1;
        x0 = 8'd1; y0 = 7'd1; color0 = 6'h01;
        x1 = 8'd2; y1 = 7'd2; color1 = 6'h02;
        for (int i = 0; i < 4; i++) begin
            step(t0, t1);
            chk("rr_grant", int'(t1), i % 2);
            if (t0) begin x0 = 8'($urandom); y0 = 7'($urandom); color0 = 6'($urandom); end
            if (t1) begin x1 = 8'($urandom); y1 = 7'($urandom); color1 = 6'($urandom); end
        end
        valid0 = 0; valid1 = 0;
        step(t0, t1);

        for (int i = 0; i < 300; i++) begin
            step(t0, t1);
            renew(t0, t1);
        end
        valid0 = 0; valid1 = 0;
        step(t0, t1);

        // pixel accepted just before clear entry, then clear racing with requester 1
        valid0 = 1; x0 = 8'd77; y0 = 7'd66; color0 = 6'h2A;
        step(t0, t1);
        chk("pre_clear_xfer", int'(t0), 1);
        valid0 = 0;
        valid1 = 1; x1 = 8'd200; y1 = 7'd100; color1 = 6'h0C;
        clear_req = 1; clear_color = 6'h3F;
        step(t0, t1);
        clear_req = 0;
        cap = 0;
        while (mclear && cap < 25000) begin
            clear_color = 6'($urandom);
            step(t0, t1);
            cap++;
        end
        chk("clear1_len", cap, XP * YP);
        step(t0, t1);
        chk("post_clear_xfer1", int'(t1), 1);
        valid1 = 0;
        step(t0, t1);

        // clear_req held through a whole clear restarts immediately
        clear_req = 1; clear_color = 6'h12;
        step(t0, t1);
        cap = 0;
        while (mclear && cap < 25000) begin
            clear_color = 6'($urandom);
            step(t0, t1);
            cap++;
        end
        chk("clear2_len", cap, XP * YP);
        clear_color = 6'h07;
        step(t0, t1);
        chk("clear_restart", int'(mclear), 1);
        clear_req = 0;
        cap = 0;
        while (!(mclear && k == 30 * XP + 51) && cap < 25000) begin
            step(t0, t1);
            cap++;
        end
        chk("mid_xyc", int'({writeEn, x, y, color}), int'({1'b1, 8'd50, 7'd30, 6'h07}));
        do_reset();
        repeat (5) step(t0, t1);

        for (int i = 0; i < 200; i++) begin
            step(t0, t1);
            renew(t0, t1);
        end
        valid0 = 0; valid1 = 0;
        step(t0, t1);
        step(t0, t1);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/pixel_write_arbiter.md
PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 Parameter COLOR_CHANNEL_DEPTH, default 2, bits per colour channel; colour width CW = 3*COLOR_CHANNEL_DEPTH.
REQ-002 Parameter X_PIXELS, default 160, screen width; parameter Y_PIXELS, default 120, screen height.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 x0, y0, color0  in  8/7/CW  requester 0 pixel; valid0 in 1 request; ready0 out 1 accept.
REQ-006 x1, y1, color1  in  8/7/CW  requester 1 pixel; valid1 in 1 request; ready1 out 1 accept.
REQ-007 clear_req  in  1  level request to fill the screen with clear_color.
REQ-008 clear_color  in  CW  fill colour, captured when the clear starts.
REQ-009 clear_busy  out  1  high while the clear sequence runs.
REQ-010 x, y, color, writeEn  out  8/7/CW/1  registered framebuffer write port.

Function
REQ-011 States: ARB, CLEAR; clear_busy = (state == CLEAR).
REQ-012 Transfer on requester i occurs at a rising edge where valid_i and ready_i are both 1; requester holds valid and data stable until transferred.
REQ-013 ready_i is combinational: 0 in CLEAR; 0 in ARB when clear_req = 1; otherwise 1 only for the requester selected by REQ-014.
REQ-014 Selection in ARB: only one valid, that one; both valid, the one not granted last (round-robin); neither valid, none; at most one ready per cycle.
REQ-015 last_grant register updates only on a transfer.
REQ-016 Accepted pixel appears on x/y/color with writeEn = 1 in the cycle after the transfer (latency 1); output carries the data unmodified, no range check.
REQ-017 Cycle with no transfer and no clear pixel: writeEn = 0, x = 0, y = 0, color = 0.
REQ-018 ARB with clear_req = 1 at an edge: state -> CLEAR, clear_color latched, cx = 0, cy = 0, no transfer that edge.
REQ-019 CLEAR: each edge loads x = cx, y = cy, color = latched colour, writeEn = 1; then cx increments; cx = X_PIXELS-1 wraps to 0 and increments cy.
REQ-020 Edge loading (X_PIXELS-1, Y_PIXELS-1): state -> ARB; clear_busy high exactly X_PIXELS*Y_PIXELS cycles (19200 default), writeEn high for the same count, delayed one cycle.
REQ-021 clear_req and clear_color ignored during CLEAR; clear_req still high on return to ARB starts a new clear immediately.
REQ-022 A pixel transferred the edge before CLEAR entry is output in the first CLEAR cycle, never dropped.
REQ-023 First ARB cycle after a clear accepts requests normally; output stream has no idle gap.

Reset
REQ-024 resetn = 0 asynchronously forces: state ARB, writeEn 0, x/y/color 0, clear_busy 0, cx/cy 0, latched colour 0, last_grant = 1 (requester 0 wins first contention).
REQ-025 Reset mid-clear aborts the clear; no further clear pixels emitted after release.
REQ-026 ready0/ready1 follow REQ-013 combinationally during reset (state ARB).

Verification
REQ-027 After reset, valid0 = 1 with (10, 20, 6'h15) alone -> ready0 = 1 that cycle; next cycle writeEn = 1, x = 10, y = 20, color = 6'h15.
REQ-028 After reset, valid0 = valid1 = 1 held for 4 cycles -> grants 0, 1, 0, 1; writeEn high 4 consecutive cycles, one cycle behind.
REQ-029 clear_req = 1 pulse, clear_color = 6'h3F -> clear_busy high 19200 cycles; writeEn 19200 cycles, first (0,0), 161st (0,1), last (159,119), all color 6'h3F; ready0/1 = 0 throughout.
REQ-030 clear_req and valid1 = 1 same cycle in ARB -> ready1 = 0, clear starts; valid1 transferred in first ARB cycle after clear, output the cycle after.
REQ-031 resetn = 0 at clear pixel (50, 30) -> outputs zero immediately; after release clear_busy = 0, writeEn = 0 with no valid inputs.
REQ-032 Idle, no valid, no clear_req -> writeEn = 0, x = 0, y = 0, color = 0 every cycle.
